seg7_scan_driver: RTL and testbench

- Parametrised time-multiplexed 7-segment scanner for the score/status readout; next generation of the team's fixed 4-digit score display.
- Adds:
  - N digits
  - full hex font
  - per-digit blank and decimal point
  - programmable on-time
  - inter-digit ghosting gap
  - input snapshot per digit
  - frame strobe
- Sits between game/score logic and board segment/anode pins.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/hex_to_seg7.sv | 16 +
 rtl/seg7_scan_driver.sv | 138 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display blocks.
// Patterns here are logical (1 = segment lit); polarity is applied at the pins.
package seg7_pkg;

    typedef enum logic {
        GAP = 1'b0,
        ON  = 1'b1
    } state_t;

    localparam logic [7:0] SEG_OFF = 8'h00;

    // Hex font, g..a in bits 6..0.
    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to logical 8-bit segment pattern {dp, g..a}.
// Blank darkens every segment including the decimal point.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] pattern
);

    always_comb begin
        pattern = blank ? SEG_OFF : {dp, FONT[value]};
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scanner with registered seg/an outputs.
// Define SEG7_LEAD_ZERO_BLANK_EN to suppress leading zeros at each digit snapshot.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int ON_CYCLES  = 50000,
    parameter int GAP_CYCLES = 500,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]      GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0]      IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_DARK = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] AN_DARK  = (ACTIVE_LOW != 0) ? '1 : '0;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic                  enter_on, tick_nxt;
    logic [7:0]            seg_nxt, pattern;
    logic [NUM_DIGITS-1:0] an_nxt, eff_blank, onehot;
    logic [3:0]            sel_value;
    logic                  sel_dp, sel_blank;

    // Effective blanking per digit, evaluated on the snapshot inputs.
    always_comb begin
        eff_blank = blank;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
        begin
            logic higher_dark;
            higher_dark = 1'b1;
            for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
                if (higher_dark && (digits[4*i +: 4] == 4'h0) && (i != 0))
                    eff_blank[i] = 1'b1;
                higher_dark = higher_dark && ((digits[4*i +: 4] == 4'h0) || blank[i]);
            end
        end
`endif
    end

    // Select the digit about to be lit; it is captured into seg on ON entry.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        sel_value = 4'h0;
        sel_dp    = 1'b0;
        sel_blank = 1'b1;
        onehot    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                sel_value = digits[4*i +: 4];
                sel_dp    = dp[i];
                sel_blank = eff_blank[i];
                onehot[i] = 1'b1;
            end
        end
    end

    hex_to_seg7 u_font (
        .value   (sel_value),
        .dp      (sel_dp),
        .blank   (sel_blank),
        .pattern (pattern)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        tick_nxt  = 1'b0;
        enter_on  = 1'b0;
        seg_nxt   = seg;
        an_nxt    = an;
        case (state)
            GAP: begin
                if (GAP_CYCLES == 0 || cnt == GAP_LAST) begin
                    state_nxt = ON;
                    cnt_nxt   = '0;
                    enter_on  = 1'b1;
                end
            end
            ON: begin
                if (cnt == ON_LAST) begin
                    cnt_nxt  = '0;
                    tick_nxt = (idx == '0);
                    idx_nxt  = (idx == '0) ? IDX_MAX : idx - 1'b1;
                    // A zero-length gap re-enters ON directly on the next digit.
                    if (GAP_CYCLES == 0) begin
                        enter_on = 1'b1;
                    end else begin
                        state_nxt = GAP;
                        seg_nxt   = SEG_DARK;
                        an_nxt    = AN_DARK;
                    end
                end
            end
            default: state_nxt = GAP;
        endcase
        if (enter_on) begin
            seg_nxt = (ACTIVE_LOW != 0) ? ~pattern : pattern;
            an_nxt  = (ACTIVE_LOW != 0) ? ~onehot  : onehot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= GAP;
            cnt        <= '0;
            idx        <= IDX_MAX;
            seg        <= SEG_DARK;
            an         <= AN_DARK;
            frame_tick <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all update together.
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            seg        <= seg_nxt;
            an         <= an_nxt;
            frame_tick <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, ON=4, GAP=1, active-low,
// plus a GAP_CYCLES=0 instance for the gapless transition.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp, blank;
    logic [7:0]  seg, seg0;
    logic [3:0]  an, an0;
    logic        tick, tick0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(4), .ON_CYCLES(4), .GAP_CYCLES(1), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .digits(digits), .dp(dp), .blank(blank),
        .seg(seg), .an(an), .frame_tick(tick)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .ON_CYCLES(4), .GAP_CYCLES(0), .ACTIVE_LOW(1)) dut_nogap (
        .clk(clk), .rst(rst), .digits(digits), .dp(dp), .blank(blank),
        .seg(seg0), .an(an0), .frame_tick(tick0)
    );

    // exp holds expected seg bytes in scan order: [31:24] digit 3 ... [7:0] digit 0.
    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Four ON cycles of one digit followed by its one-cycle gap.
    task automatic check_slot(input string tag, input logic [3:0] ea, input logic [7:0] es,
                              input logic tick_after);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check({tag, " an"}, {4'h0, an}, {4'h0, ea});
            check({tag, " seg"}, seg, es);
            check({tag, " tick_on"}, {7'h0, tick}, 8'h00);
        end
        @(negedge clk);
        check({tag, " gap an"}, {4'h0, an}, 8'h0F);
        check({tag, " gap seg"}, seg, 8'hFF);
        check({tag, " gap tick"}, {7'h0, tick}, {7'h0, tick_after});
    endtask

    task automatic run_frame(input string tag, input logic [31:0] exp);
        for (int s = 0; s < 4; s++) begin
            logic [3:0] ea;
            ea = ~(4'b1000 >> s);
            check_slot(tag, ea, exp[31-8*s -: 8], s == 3);
        end
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 32'hF9A4B099};
        vecs[1] = '{16'hABCD, 4'b0010, 4'b0000, 32'h888346A1};
        vecs[2] = '{16'h1234, 4'b0000, 4'b1000, 32'hFFA4B099};
        vecs[3] = '{16'h5678, 4'b1111, 4'b0100, 32'h12FF7800};
        vecs[6] = '{16'h9EF0, 4'b0000, 4'b0000, 32'h90868EC0};
`ifdef SEG7_LEAD_ZERO_BLANK_EN
        vecs[4] = '{16'h0070, 4'b0000, 4'b0000, 32'hFFFFF8C0};
        vecs[5] = '{16'h0000, 4'b0000, 4'b0000, 32'hFFFFFFC0};
`else
        vecs[4] = '{16'h0070, 4'b0000, 4'b0000, 32'hC0C0F8C0};
        vecs[5] = '{16'h0000, 4'b0000, 4'b0000, 32'hC0C0C0C0};
`endif

        rst    = 1'b1;
        digits = 16'h1234;
        dp     = 4'h0;
        blank  = 4'h0;
        repeat (2) @(negedge clk);
        check("reset an", {4'h0, an}, 8'h0F);
        check("reset seg", seg, 8'hFF);
        check("reset tick", {7'h0, tick}, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("first gap an", {4'h0, an}, 8'h0F);
        check("first gap seg", seg, 8'hFF);

        // Inputs change at the gap sample before digit 3 is snapshotted.
        for (int v = 0; v < 7; v++) begin
            digits = vecs[v].digits;
            dp     = vecs[v].dp;
            blank  = vecs[v].blank;
            run_frame($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Mid-ON change of digit 0 is held until its next turn.
        digits = 16'h1234;
        dp     = 4'h0;
        blank  = 4'h0;
        check_slot("mid d3", 4'b0111, 8'hF9, 1'b0);
        check_slot("mid d2", 4'b1011, 8'hA4, 1'b0);
        check_slot("mid d1", 4'b1101, 8'hB0, 1'b0);
        @(negedge clk);
        check("mid d0 an", {4'h0, an}, 8'h0E);
        check("mid d0 seg", seg, 8'h99);
        digits = 16'h1235;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid d0 hold", seg, 8'h99);
        end
        @(negedge clk);
        check("mid gap tick", {7'h0, tick}, 8'h01);
        run_frame("mid next", 32'hF9A4B092);

        // Reset in the middle of digit 3's ON period.
        digits = 16'h1234;
        repeat (2) @(negedge clk);
        check("pre-rst an", {4'h0, an}, 8'h07);
        rst = 1'b1;
        #1;
        check("async rst an", {4'h0, an}, 8'h0F);
        check("async rst seg", seg, 8'hFF);
        check("async rst an nogap", {4'h0, an0}, 8'h0F);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post-rst gap an", {4'h0, an}, 8'h0F);
        run_frame("post-rst", 32'hF9A4B099);

        // Gapless instance: digits switch with no dark cycle.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("nogap start an", {4'h0, an0}, 8'h0F);
        for (int s = 0; s < 4; s++) begin
            logic [3:0] ea;
            logic [31:0] exp;
            exp = 32'hF9A4B099;
            ea  = ~(4'b1000 >> s);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check("nogap an", {4'h0, an0}, {4'h0, ea});
                check("nogap seg", seg0, exp[31-8*s -: 8]);
                check("nogap tick", {7'h0, tick0}, 8'h00);
            end
        end
        @(negedge clk);
        check("nogap wrap an", {4'h0, an0}, 8'h07);
        check("nogap wrap seg", seg0, 8'hF9);
        check("nogap wrap tick", {7'h0, tick0}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
